// File: rtl/mult_wb_merge_pkg.sv
// Shared widths, depths and types for the multiply writeback merge stage.
package mult_wb_merge_pkg;

  localparam int REG_SIZE        = 32;
  localparam int REG_ADDR        = 5;
  localparam int WB_FIFO_DEPTH   = 4;
  localparam int WB_STALL_THRESH = 2;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_FIFO,
    SRC_BYPASS
  } wb_src_e;

endpackage

// File: rtl/mult_wb_merge_fifo.sv
// Circular buffer of pending multiply results; entries can be invalidated in place
// by a later ALU write to the same register and still pop normally.
module mult_wb_fifo
  import mult_wb_merge_pkg::*;
#(
  parameter int DATA_W = REG_SIZE,
  parameter int ADDR_W = REG_ADDR,
  parameter int DEPTH  = WB_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [ADDR_W-1:0]          push_wreg,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       push_zero,
  input  logic                       pop,
  input  logic                       squash_en,
  input  logic [ADDR_W-1:0]          squash_addr,
  output logic                       head_valid,
  output logic [ADDR_W-1:0]          head_wreg,
  output logic [DATA_W-1:0]          head_data,
  output logic                       head_zero,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  zero_q;
  logic [ADDR_W-1:0] wreg_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head_valid = valid_q[head_q];
  assign head_wreg  = wreg_q[head_q];
  assign head_data  = data_q[head_q];
  assign head_zero  = zero_q[head_q];

  // Squash runs before the push so a fresh entry written this cycle keeps valid=1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count   <= '0;
      valid_q <= '0;
      zero_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        wreg_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (squash_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wreg_q[i] == squash_addr) valid_q[i] <= 1'b0;
        end
      end
      if (do_push) begin
        valid_q[tail_q] <= 1'b1;
        wreg_q[tail_q]  <= push_wreg;
        data_q[tail_q]  <= push_data;
        zero_q[tail_q]  <= push_zero;
        tail_q          <= tail_q + 1'b1;
      end
      if (do_pop) head_q <= head_q + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/mult_wb_merge.sv
// Writeback merge: arbitrates the single register-file write port between the
// ALU/MEM pipe (always wins) and buffered multiply results.
module mult_wb_merge
  import mult_wb_merge_pkg::*;
#(
  parameter int DATA_W       = REG_SIZE,
  parameter int ADDR_W       = REG_ADDR,
  parameter int DEPTH        = WB_FIFO_DEPTH,
  parameter int STALL_THRESH = WB_STALL_THRESH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regwrite_mult_in,
  input  logic [ADDR_W-1:0] wreg_mult_in,
  input  logic [DATA_W-1:0] mresult_in,
  input  logic              mzero_in,
  input  logic              moverflow_in,
  input  logic              regwrite_alu_in,
  input  logic [ADDR_W-1:0] wreg_alu_in,
  input  logic [DATA_W-1:0] alu_result_in,
  output logic              regwrite_out,
  output logic [ADDR_W-1:0] wreg_out,
  output logic [DATA_W-1:0] wdata_out,
  output logic              zero_out,
  output logic              mult_stall_out,
  output logic              overflow_exc_out,
  output logic              fifo_ovf_out
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              alu_wins;
  logic              mult_ok;
  logic              fifo_push;
  logic              fifo_pop;
  logic              push_drop;
  logic              head_valid;
  logic [ADDR_W-1:0] head_wreg;
  logic [DATA_W-1:0] head_data;
  logic              head_zero;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  wb_src_e           src;
  logic              nxt_we;
  logic [ADDR_W-1:0] nxt_wreg;
  logic [DATA_W-1:0] nxt_wdata;
  logic              nxt_zero;

  mult_wb_fifo #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .push_wreg  (wreg_mult_in),
    .push_data  (mresult_in),
    .push_zero  (mzero_in),
    .pop        (fifo_pop),
    .squash_en  (alu_wins),
    .squash_addr(wreg_alu_in),
    .head_valid (head_valid),
    .head_wreg  (head_wreg),
    .head_data  (head_data),
    .head_zero  (head_zero),
    .count      (fifo_count),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  // A same-cycle ALU write to the mult's target makes the older mult result dead.
  always_comb begin
    alu_wins  = regwrite_alu_in && (wreg_alu_in != '0);
    mult_ok   = regwrite_mult_in && !moverflow_in && (wreg_mult_in != '0) &&
                !(regwrite_alu_in && (wreg_alu_in == wreg_mult_in));
    src       = SRC_NONE;
    fifo_pop  = 1'b0;
    nxt_we    = 1'b0;
    nxt_wreg  = '0;
    nxt_wdata = '0;
    nxt_zero  = 1'b0;
    if (alu_wins) begin
      src = SRC_ALU;
    end else if (!fifo_empty) begin
      src      = SRC_FIFO;
      fifo_pop = 1'b1;
    end else if (mult_ok) begin
      src = SRC_BYPASS;
    end
    fifo_push = mult_ok && (src != SRC_BYPASS);
    push_drop = fifo_push && fifo_full && !fifo_pop;
    case (src)
      SRC_ALU: begin
        nxt_we    = 1'b1;
        nxt_wreg  = wreg_alu_in;
        nxt_wdata = alu_result_in;
      end
      SRC_FIFO: begin
        if (head_valid) begin
          nxt_we    = 1'b1;
          nxt_wreg  = head_wreg;
          nxt_wdata = head_data;
          nxt_zero  = head_zero;
        end
      end
      SRC_BYPASS: begin
        nxt_we    = 1'b1;
        nxt_wreg  = wreg_mult_in;
        nxt_wdata = mresult_in;
        nxt_zero  = mzero_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regwrite_out     <= 1'b0;
      wreg_out         <= '0;
      wdata_out        <= '0;
      zero_out         <= 1'b0;
      overflow_exc_out <= 1'b0;
      fifo_ovf_out     <= 1'b0;
    end else begin
      regwrite_out     <= nxt_we;
      wreg_out         <= nxt_wreg;
      wdata_out        <= nxt_wdata;
      zero_out         <= nxt_zero;
      overflow_exc_out <= regwrite_mult_in && moverflow_in;
      fifo_ovf_out     <= fifo_ovf_out || push_drop;
    end
  end

  assign mult_stall_out = (fifo_count >= CNT_W'(STALL_THRESH));

endmodule
